// File: rtl/fft_bf_seq_pkg.sv
// Shared definitions for the in-place FFT butterfly sequencer: FSM encoding,
// default transform size / datapath latency and sample data widths.
package fft_bf_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_LOG2N    = 9;
    localparam int DEF_PIPE_LAT = 4;

    // Complex sample format carried by the butterfly datapath.
    localparam int DATA_W       = 16;
    localparam int SAMPLE_W     = 2 * DATA_W;

endpackage

// File: rtl/fft_bf_addr.sv
// Butterfly leg addresses and twiddle index for butterfly j of stage s
// (radix-2, in place, decimation-in-time ordering).
module fft_bf_addr
    import fft_bf_seq_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N,
    parameter int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-2:0] j,
    input  logic             inv,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] tw_idx
);

    logic [LOG2N-1:0] jw;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] tw;

    always_comb begin
        jw     = {1'b0, j};
        span   = LOG2N'(1) << stage;
        pos    = jw & (span - LOG2N'(1));
        grp    = jw >> stage;
        // Insert a zero at bit s of j: upper leg; the lower leg sets that bit.
        addr_a = ((grp << stage) << 1) | pos;
        addr_b = addr_a | span;
        tw     = pos << (SW'(LOG2N - 1) - stage);
        // Inverse transform uses the conjugate twiddle, i.e. (N - k) mod N.
        tw_idx = inv ? (LOG2N'(0) - tw) : tw;
    end

endmodule

// File: rtl/fft_bf_seq.sv
// Sequencer that walks all butterflies of an in-place radix-2 FFT, stage by
// stage, draining the butterfly datapath between stages.
module fft_bf_seq
    import fft_bf_seq_pkg::*;
#(
    parameter int LOG2N    = DEF_LOG2N,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    localparam int SW      = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inv,
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] tw_idx,
    output logic [SW-1:0]    stage,
    output logic             bf_last
);

    localparam logic [LOG2N-2:0] J_LAST     = {(LOG2N-1){1'b1}};
    localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [3:0]       CNT_LAST   = 4'(PIPE_LAT - 1);

    // Handshake: a butterfly transfers on a rising edge where bf_valid and
    // bf_ready are both high; while bf_ready is low every issue output holds.

    state_t            state_q, state_d;
    logic [LOG2N-2:0]  j_q, j_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic              inv_q, inv_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [LOG2N-1:0]  nxt_a, nxt_b, nxt_tw;
    logic [LOG2N-1:0]  addr_a_d, addr_b_d, tw_idx_d;
    logic              bf_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            addr_a  <= '0;
            addr_b  <= '0;
            tw_idx  <= '0;
            bf_last <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
            addr_a  <= addr_a_d;
            addr_b  <= addr_b_d;
            tw_idx  <= tw_idx_d;
            bf_last <= bf_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    j_d     = '0;
                    stage_d = '0;
                    inv_d   = inv;
                end
            end
            S_ISSUE: begin
                if (bf_ready) begin
                    if (j_q == J_LAST) begin
                        state_d = S_DRAIN;
                        j_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_DONE;
                        stage_d = '0;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Addresses are computed for the next (stage, j) so the registered outputs
    // line up with bf_valid in the cycle the FSM is in ISSUE.
    fft_bf_addr #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr (
        .stage  (stage_d),
        .j      (j_d),
        .inv    (inv_d),
        .addr_a (nxt_a),
        .addr_b (nxt_b),
        .tw_idx (nxt_tw)
    );

    always_comb begin
        addr_a_d  = '0;
        addr_b_d  = '0;
        tw_idx_d  = '0;
        bf_last_d = 1'b0;
        if (state_d == S_ISSUE) begin
            addr_a_d  = nxt_a;
            addr_b_d  = nxt_b;
            tw_idx_d  = nxt_tw;
            bf_last_d = (stage_d == STAGE_LAST) && (j_d == J_LAST);
        end
    end

    assign bf_valid = (state_q == S_ISSUE);
    assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign stage    = stage_q;

endmodule

// File: tb/tb_fft_bf_seq.sv
// Scoreboard bench for fft_bf_seq at N=512, PIPE_LAT=4: full passes with and
// without bf_ready stalls, inverse twiddles, and a reset in the middle of a pass.
module tb_fft_bf_seq;

    localparam int LOG2N = 9;
    localparam int PLAT  = 4;
    localparam int NBF   = 2304;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       inv = 1'b0;
    logic       bf_ready = 1'b1;
    logic       busy, done, bf_valid, bf_last;
    logic [8:0] addr_a, addr_b, tw_idx;
    logic [3:0] stage;

    fft_bf_seq #(.LOG2N(LOG2N), .PIPE_LAT(PLAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inv      (inv),
        .busy     (busy),
        .done     (done),
        .bf_valid (bf_valid),
        .bf_ready (bf_ready),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .tw_idx   (tw_idx),
        .stage    (stage),
        .bf_last  (bf_last)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] hs_log[NBF];
    int tests = 0;
    int fails = 0;
    int hs_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int busy_first = 0;
    int busy_last = 0;
    bit busy_seen = 0;
    bit stall_en = 0;

    function automatic logic [31:0] pk(input int a, input int b, input int t,
                                       input int s, input bit l);
        logic [31:0] v;
        v = {a[8:0], b[8:0], t[8:0], s[3:0], l};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests = tests + 1;
        if (got !== want) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Expected butterfly order: groups outer, positions inner within each stage.
    task automatic push_expected(input bit inv_sel);
        for (int s = 0; s < LOG2N; s++) begin
            int half = 1 << s;
            int ngrp = 256 / half;
            for (int g = 0; g < ngrp; g++) begin
                for (int p = 0; p < half; p++) begin
                    int a = g * 2 * half + p;
                    int t = p * (256 / half);
                    if (inv_sel && t != 0) t = 512 - t;
                    exp_q.push_back(pk(a, a + half, t, s,
                                       (s == 8) && (g == ngrp - 1) && (p == half - 1)));
                end
            end
        end
    endtask

    // ---------------- bf_ready driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        bf_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // ---------------- monitor ----------------
    initial begin
        bit          prev_stall = 0;
        logic [31:0] prev_out = '0;
        logic [31:0] cur;
        int          gap = 0;
        forever begin
            @(negedge clk);
            cur = {addr_a, addr_b, tw_idx, stage, bf_last};
            if (!rst_n) begin
                prev_stall = 0;
                gap = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", cur, prev_out);
                    check("stall_valid", 32'(bf_valid), 32'd1);
                end
                prev_stall = bf_valid && !bf_ready;
                prev_out = cur;
                if (bf_valid && bf_ready) begin
                    if (exp_q.size() == 0) begin
                        check("bf_unexpected", cur, 32'hFFFF_FFFF);
                    end else begin
                        check("bf", cur, exp_q.pop_front());
                    end
                    if (hs_count < NBF) hs_log[hs_count] = cur;
                    hs_count = hs_count + 1;
                end
                if (busy && !bf_valid) begin
                    gap = gap + 1;
                end else if (bf_valid && gap != 0) begin
                    check("drain_len", 32'(gap), 32'(PLAT));
                    gap = 0;
                end
                if (busy) begin
                    if (!busy_seen) busy_first = cyc;
                    busy_seen = 1;
                    busy_last = cyc;
                    busy_cnt = busy_cnt + 1;
                end
                if (done) begin
                    done_count = done_count + 1;
                    done_cyc = cyc;
                    check("final_drain_len", 32'(gap), 32'(PLAT));
                    gap = 0;
                    check("done_outputs", {busy, bf_valid, bf_last, addr_a, addr_b, tw_idx, stage},
                          32'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int budget, input int d0);
        int n = 0;
        while (done_count == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 32'(done_count != d0), 32'd1);
    endtask

    task automatic launch(input bit inv_sel, input bit stall, output int c0);
        hs_count = 0;
        busy_cnt = 0;
        busy_seen = 0;
        stall_en = stall;
        @(posedge clk);
        #2;
        inv = inv_sel;
        start = 1'b1;
        c0 = cyc;
    endtask

    task automatic run_pass(input bit inv_sel, input bit stall, input bit hold_start,
                            output int c0);
        int d0;
        push_expected(inv_sel);
        d0 = done_count;
        launch(inv_sel, stall, c0);
        @(posedge clk);
        #2;
        if (!hold_start) start = 1'b0;
        inv = ~inv_sel;
        wait_done(8000, d0);
        #2;
        start = 1'b0;
        stall_en = 0;
        repeat (3) @(posedge clk);
        #2;
        check("done_pulses", 32'(done_count - d0), 32'd1);
        check("handshakes", 32'(hs_count), 32'(NBF));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int d0;
        int n;

        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {busy, done, bf_valid, bf_last, addr_a, addr_b, tw_idx, stage}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Forward pass, no stalls: exact cycle timing.
        run_pass(1'b0, 1'b0, 1'b0, c0);
        check("done_cycle", 32'(done_cyc - c0), 32'd2341);
        check("busy_first", 32'(busy_first - c0), 32'd1);
        check("busy_last", 32'(busy_last - c0), 32'd2340);
        check("busy_cycles", 32'(busy_cnt), 32'd2340);
        check("s0_j0", hs_log[0], pk(0, 1, 0, 0, 0));
        check("s0_j1", hs_log[1], pk(2, 3, 0, 0, 0));
        check("s1_j1_fwd", hs_log[257], pk(1, 3, 128, 1, 0));
        check("s8_j0", hs_log[2048], pk(0, 256, 0, 8, 0));
        check("s8_j1", hs_log[2049], pk(1, 257, 1, 8, 0));
        check("s8_j255", hs_log[2303], pk(255, 511, 255, 8, 1));

        // Inverse pass with random stalls; start held high through DONE.
        run_pass(1'b1, 1'b1, 1'b1, c0);
        check("s1_j1_inv", hs_log[257], pk(1, 3, 384, 1, 0));
        check("s8_j1_inv", hs_log[2049], pk(1, 257, 511, 8, 0));

        // Reset in the middle of stage 3.
        push_expected(1'b0);
        d0 = done_count;
        launch(1'b0, 1'b0, c0);
        @(posedge clk);
        #2;
        start = 1'b0;
        n = 0;
        while (stage != 4'd3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_stage3", 32'(stage), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midpass_rst_outputs",
              {busy, done, bf_valid, bf_last, addr_a, addr_b, tw_idx, stage}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("no_done_after_rst", 32'(done_count - d0), 32'd0);
        check("idle_after_rst", 32'(busy), 32'd0);

        run_pass(1'b0, 1'b0, 1'b0, c0);
        check("restart_s0_j0", hs_log[0], pk(0, 1, 0, 0, 0));
        check("restart_done_cycle", 32'(done_cyc - c0), 32'd2341);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        fails = fails + 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
